// File: rtl/buffer_pkg.sv
// Shared types and defaults for the two-source bus buffer.
// Holds the bus-owner encodings and default widths.
package buffer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    SEL_NONE     = 2'b00,
    SEL_1        = 2'b01,
    SEL_2        = 2'b10,
    SEL_CONFLICT = 2'b11
  } sel_e;

endpackage

// File: rtl/buffer_sat_counter.sv
// Saturating up-counter with synchronous clear and active-low reset.
// Ports: clk_i, rst_ni, inc_i, clr_i (wins over inc_i), cnt_o.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/buffer.sv
// Registered two-source bus buffer: merges two enabled sources onto one bus.
// Ports: data_en1/2, data_in1/2, cnt_clr in; data_out, data_valid,
// src_sel, conflict, conflict_cnt out. Source 1 wins contention.
module buffer
  import buffer_pkg::*;
#(
  parameter int data_width = DATA_W_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF,
  parameter int IDLE_HOLD  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_en1,
  input  logic                  data_en2,
  input  logic [data_width-1:0] data_in1,
  input  logic [data_width-1:0] data_in2,
  input  logic                  cnt_clr,
  output logic [data_width-1:0] data_out,
  output logic                  data_valid,
  output logic [1:0]            src_sel,
  output logic                  conflict,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  logic [data_width-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  sel_e                  sel_q, sel_d;
  logic                  conf_q, conf_d;

  // Data is only ever taken from an enabled source, so an undriven
  // (X) input behind a low enable never reaches the bus.
  always_comb begin
    data_d  = (IDLE_HOLD != 0) ? data_q : '0;
    valid_d = 1'b0;
    sel_d   = SEL_NONE;
    conf_d  = 1'b0;
    unique case ({data_en1, data_en2})
      2'b10: begin
        data_d  = data_in1;
        valid_d = 1'b1;
        sel_d   = SEL_1;
      end
      2'b01: begin
        data_d  = data_in2;
        valid_d = 1'b1;
        sel_d   = SEL_2;
      end
      2'b11: begin
        data_d  = data_in1;
        valid_d = 1'b1;
        sel_d   = SEL_CONFLICT;
        conf_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= SEL_NONE;
      conf_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      conf_q  <= conf_d;
    end
  end

  sat_counter #(
    .W (CNT_WIDTH)
  ) u_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (data_en1 & data_en2),
    .clr_i  (cnt_clr),
    .cnt_o  (conflict_cnt)
  );

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign src_sel    = sel_q;
  assign conflict   = conf_q;

endmodule

// File: tb/tb_buffer.sv
// Randomized self-checking bench for buffer, two parameter sets.
// Compares every cycle against a behavioural model of the bus rules.
module tb_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en1, en2, clr;
  logic [7:0] in1, in2;

  logic [7:0] d0_out, d1_out;
  logic       d0_vld, d1_vld;
  logic [1:0] d0_sel, d1_sel;
  logic       d0_cf, d1_cf;
  logic [7:0] d0_cnt;
  logic [1:0] d1_cnt;

  always #5 clk = ~clk;

  buffer #(.data_width(8), .CNT_WIDTH(8), .IDLE_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .data_en1(en1), .data_en2(en2),
    .data_in1(in1), .data_in2(in2),
    .cnt_clr(clr),
    .data_out(d0_out), .data_valid(d0_vld),
    .src_sel(d0_sel), .conflict(d0_cf),
    .conflict_cnt(d0_cnt)
  );

  buffer #(.data_width(8), .CNT_WIDTH(2), .IDLE_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .data_en1(en1), .data_en2(en2),
    .data_in1(in1), .data_in2(in2),
    .cnt_clr(clr),
    .data_out(d1_out), .data_valid(d1_vld),
    .src_sel(d1_sel), .conflict(d1_cf),
    .conflict_cnt(d1_cnt)
  );

  typedef struct {
    int dout;
    int valid;
    int sel;
    int conf;
    int cnt;
  } mdl_t;

  mdl_t m [2];
  int   hold [2] = '{0, 1};
  int   cmax [2] = '{255, 3};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int i);
    if (!rst_n) begin
      m[i].dout  = 0;
      m[i].valid = 0;
      m[i].sel   = 0;
      m[i].conf  = 0;
      m[i].cnt   = 0;
    end else begin
      if (en1)      m[i].dout = int'(in1);
      else if (en2) m[i].dout = int'(in2);
      else if (hold[i] == 0) m[i].dout = 0;
      m[i].valid = (en1 || en2) ? 1 : 0;
      m[i].sel   = (en2 ? 2 : 0) + (en1 ? 1 : 0);
      m[i].conf  = (en1 && en2) ? 1 : 0;
      if (clr) m[i].cnt = 0;
      else if (en1 && en2 && m[i].cnt < cmax[i]) m[i].cnt++;
    end
  endtask

  task automatic cmp_all();
    check("d0_out", 32'(d0_out), m[0].dout);
    check("d0_vld", 32'(d0_vld), m[0].valid);
    check("d0_sel", 32'(d0_sel), m[0].sel);
    check("d0_cf",  32'(d0_cf),  m[0].conf);
    check("d0_cnt", 32'(d0_cnt), m[0].cnt);
    check("d1_out", 32'(d1_out), m[1].dout);
    check("d1_vld", 32'(d1_vld), m[1].valid);
    check("d1_sel", 32'(d1_sel), m[1].sel);
    check("d1_cf",  32'(d1_cf),  m[1].conf);
    check("d1_cnt", 32'(d1_cnt), m[1].cnt);
  endtask

  task automatic step(input bit r, input bit e1, input bit e2,
                      input logic [7:0] a, input logic [7:0] b,
                      input bit c);
    rst_n = r;
    en1   = e1;
    en2   = e2;
    in1   = a;
    in2   = b;
    clr   = c;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    cmp_all();
  endtask

  initial begin
    rst_n = 1'b0;
    en1 = 1'b0; en2 = 1'b0; clr = 1'b0;
    in1 = 8'h00; in2 = 8'h00;
    @(negedge clk);

    // reset held with a source requesting the bus
    step(0, 1, 0, 8'h01, 8'h02, 0);
    step(0, 1, 0, 8'h01, 8'h02, 0);
    check("rst_out", 32'(d0_out), 32'h0);

    // single sources
    step(1, 1, 0, 8'h01, 8'h02, 0);
    check("src1_out", 32'(d0_out), 32'h01);
    step(1, 0, 1, 8'h01, 8'h02, 0);
    check("src2_sel", 32'(d0_sel), 32'h2);

    // contention, three cycles
    step(1, 1, 1, 8'h01, 8'h02, 0);
    step(1, 1, 1, 8'h01, 8'h02, 0);
    step(1, 1, 1, 8'h01, 8'h02, 0);
    check("cnt3", 32'(d0_cnt), 32'd3);

    // idle after data 0x02
    step(1, 0, 1, 8'h01, 8'h02, 0);
    step(1, 0, 0, 8'h55, 8'hAA, 0);
    check("idle_clr", 32'(d0_out), 32'h00);
    check("idle_hold", 32'(d1_out), 32'h02);

    // saturation of the narrow counter, then clear vs increment
    for (int k = 0; k < 5; k++) step(1, 1, 1, 8'h01, 8'h02, 0);
    check("sat", 32'(d1_cnt), 32'd3);
    step(1, 1, 1, 8'h01, 8'h02, 1);
    check("clr_cnt", 32'(d1_cnt), 32'd0);
    check("clr_cf", 32'(d1_cf), 32'd1);

    // mid-run reset then release on source 2
    step(1, 1, 0, 8'h01, 8'h02, 0);
    step(0, 1, 0, 8'h01, 8'h02, 0);
    step(1, 0, 1, 8'h01, 8'h02, 0);
    check("post_rst", 32'(d0_out), 32'h02);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(31) != 0),
           1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom),
           ($urandom_range(15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer.md
Name: buffer

Overview:
- Registered two-source bus buffer: two enable-qualified data inputs are merged onto one output bus.
- Replaces a pair of tri-state drivers on a shared bus with a clocked, conflict-safe multiplexer.
- Reports which source owns the bus and flags and counts contention (both enables high).
- Sits between two producers and a single consumer bus.

Parameters:
- data_width, 8, width of data_in1, data_in2, data_out.
- CNT_WIDTH, 8, width of the saturating conflict counter.
- IDLE_HOLD, 0, idle behaviour: 0 = data_out clears to 0 when no enable is high; 1 = data_out holds its last value.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- data_en1  input  1  source 1 drive request.
- data_en2  input  1  source 2 drive request.
- data_in1  input  data_width  source 1 data.
- data_in2  input  data_width  source 2 data.
- cnt_clr  input  1  synchronous clear of conflict_cnt.
- data_out  output  data_width  registered bus value.
- data_valid  output  1  high when data_out was driven by a source in the previous cycle.
- src_sel  output  2  owner of the bus: 00 none, 01 source 1, 10 source 2, 11 conflict.
- conflict  output  1  registered contention flag.
- conflict_cnt  output  CNT_WIDTH  saturating count of conflict cycles.

Behaviour:
- All outputs are registered on the rising edge of clk. Latency is 1 cycle from inputs to outputs.
- Reset (rst_n=0 sampled at an edge): data_out=0, data_valid=0, src_sel=00, conflict=0, conflict_cnt=0.
  - Reset has priority over every other input, including when it is asserted mid-stream.
- Per cycle, evaluated on {data_en1, data_en2}:
  - 10: data_out<=data_in1, data_valid<=1, src_sel<=01, conflict<=0.
  - 01: data_out<=data_in2, data_valid<=1, src_sel<=10, conflict<=0.
  - 11: source 1 has fixed priority. data_out<=data_in1, data_valid<=1, src_sel<=11, conflict<=1.
    - conflict_cnt increments by 1, saturating at all-ones. It does not wrap.
  - 00: data_valid<=0, src_sel<=00, conflict<=0.
    - data_out<=0 if IDLE_HOLD=0; data_out holds its value if IDLE_HOLD=1.
- cnt_clr=1: conflict_cnt<=0. This has priority over the increment in the same cycle. All other outputs behave normally.
- conflict_cnt is otherwise unchanged.
- Purely synchronous design: no tri-states, no latches, no combinational input-to-output path.
- Inputs that are X while their enable is low must not propagate to data_out.

Decomposition:
- Shared package buffer_pkg:
  - src_sel encodings: SEL_NONE=2'b00, SEL_1=2'b01, SEL_2=2'b10, SEL_CONFLICT=2'b11.
  - Default widths.
- One sub-module: sat_counter (parameterised width, inc, clr, synchronous active-low reset, saturates at max), used for conflict_cnt.
- The mux/decode stays in the top level.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with en1=1, in1=0x01 -> data_out=0x00, data_valid=0, src_sel=00, conflict=0, conflict_cnt=0.
- Single sources: en1=1, en2=0, in1=0x01, in2=0x02 -> next cycle data_out=0x01, src_sel=01, valid=1. Then en1=0, en2=1 -> data_out=0x02, src_sel=10.
- Contention: en1=en2=1, in1=0x01, in2=0x02 -> data_out=0x01, src_sel=11, conflict=1, conflict_cnt=1. Hold 3 cycles -> conflict_cnt=3.
- Idle: en1=en2=0 after data 0x02 -> IDLE_HOLD=0 gives data_out=0x00, valid=0, src_sel=00. IDLE_HOLD=1 gives data_out stays 0x02, valid=0.
- Saturation/clear: CNT_WIDTH=2, 5 conflict cycles -> conflict_cnt=3 and stays 3. cnt_clr=1 with en1=en2=1 -> conflict_cnt=0, conflict=1.
- Mid-run reset: rst_n=0 during en1=1, in1=0x01 -> all outputs 0 next edge. Release rst_n with en1=0, en2=1, in2=0x02 -> data_out=0x02 one cycle later.
